// File: rtl/ysyx_22041207_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_ifu -- instruction fetch unit
//
// Owns the architectural fetch PC. It issues one request at a time on a
// valid/ready instruction-memory port. The fetched word is presented to the
// IF/ID register as an inst/pc pair. That pair is held while decode stalls
// (bubble). A redirect loads a new PC, and any response still in flight at
// that moment is thrown away.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous reset, active high
//   bubble          decode stalled: hold the current inst/pc
//   redirect_valid  control-flow change this cycle
//   redirect_pc     new fetch PC (word aligned, stored unchanged)
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request
//   imem_req_addr   fetch address (always the internal fetch PC)
//   imem_resp_valid read data valid, one per accepted request
//   imem_resp_data  instruction word
//   inst            instruction to IF/ID, zero unless inst_valid
//   pc              PC of inst, zero unless inst_valid
//   inst_valid      inst/pc carry a live instruction
// ---------------------------------------------------------------------------
module ysyx_22041207_ifu #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_valid
);

    // REQ     : address on the port, waiting for acceptance
    // WAIT    : request accepted, waiting for its response
    // DISCARD : request accepted but since redirected; drop its response
    // HOLD    : instruction delivered, held until decode takes it
    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [31:0]       inst_r;
    logic [31:0]       inst_nxt_s;
    logic              accept_s;
    logic              hold_s;

    // The handshake completes only when a request is actually being offered.
    assign accept_s = imem_req_valid && imem_req_ready;

    // Next-state, next-PC and next-instruction selection; redirect wins everywhere.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        inst_nxt_s  = inst_r;
        case (state_r)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_pc;
                    // The old address may already have been taken by memory.
                    // In that case its response must still be drained.
                    if (accept_s) begin
                        state_nxt_s = ST_DISCARD;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect_valid) begin
                        // The response belongs to the old path, so it is dropped.
                        pc_nxt_s    = redirect_pc;
                        state_nxt_s = ST_REQ;
                    end else begin
                        inst_nxt_s  = imem_resp_data;
                        state_nxt_s = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_nxt_s    = redirect_pc;
                    state_nxt_s = ST_DISCARD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
                // Leave only once the stale response has been swallowed.
                // Otherwise two requests could be in flight at once.
                if (imem_resp_valid) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_pc;
                    state_nxt_s = ST_REQ;
                end else if (!bubble) begin
                    // Sequential advance; wraps naturally at the top of the space.
                    pc_nxt_s    = pc_r + ADDR_W'(4);
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // State, fetch PC and held instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
            inst_r  <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            inst_r  <= inst_nxt_s;
        end
    end

    // Outputs decode the registered state. Reset forces them quiet in the
    // same cycle, even before the first reset edge has been seen.
    assign hold_s         = (state_r == ST_HOLD) && !rst;
    assign imem_req_valid = (state_r == ST_REQ) && !rst;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = hold_s;
    assign inst           = hold_s ? inst_r : 32'd0;
    assign pc             = hold_s ? pc_r : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
module tb_ysyx_22041207_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        bubble;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_valid;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22041207_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .bubble          (bubble),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .pc              (pc),
        .inst_valid      (inst_valid)
    );

    always #5 clk = ~clk;

    // One rising edge; inputs set after return are seen by the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From REQ: expect addr, get it accepted, return data after lat cycles, check delivery.
    task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [31:0] data, input int lat);
        chk({tag, "_reqv"}, {63'd0, imem_req_valid}, 64'd1);
        chk({tag, "_addr"}, imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk({tag, "_one_outstanding"}, {63'd0, imem_req_valid}, 64'd0);
            step();
        end
        chk({tag, "_wait_reqv"}, {63'd0, imem_req_valid}, 64'd0);
        chk({tag, "_wait_ivalid"}, {63'd0, inst_valid}, 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        chk({tag, "_ivalid"}, {63'd0, inst_valid}, 64'd1);
        chk({tag, "_inst"}, {32'd0, inst}, {32'd0, data});
        chk({tag, "_pc"}, pc, addr);
    endtask

    initial begin
        rst             = 1'b1;
        bubble          = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'd0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;

        // Reset held for two edges
        step();
        chk("rst_reqv", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_ivalid", {63'd0, inst_valid}, 64'd0);
        step();
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_pc", pc, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_addr", imem_req_addr, 64'h8000_0000);

        // First fetch, one-cycle latency
        do_fetch("first", 64'h8000_0000, 32'h0000_0013, 1);

        // Sequential stream with varying latency
        step();
        chk("seq1_ivalid", {63'd0, inst_valid}, 64'd0);
        chk("seq1_inst_zero", {32'd0, inst}, 64'd0);
        do_fetch("seq1", 64'h8000_0004, 32'h8000_0017, 2);
        step();
        do_fetch("seq2", 64'h8000_0008, 32'h8000_001B, 3);

        // Bubble hold for five cycles
        bubble = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bub_ivalid", {63'd0, inst_valid}, 64'd1);
            chk("bub_inst", {32'd0, inst}, 64'h0000_0000_8000_001B);
            chk("bub_pc", pc, 64'h8000_0008);
            chk("bub_noreq", {63'd0, imem_req_valid}, 64'd0);
        end
        bubble = 1'b0;
        step();
        chk("bub_rel_reqv", {63'd0, imem_req_valid}, 64'd1);
        chk("bub_rel_addr", imem_req_addr, 64'h8000_000C);

        // Address stays stable while not accepted
        step();
        chk("stall_reqv", {63'd0, imem_req_valid}, 64'd1);
        chk("stall_addr", imem_req_addr, 64'h8000_000C);

        // Redirect in WAIT before the response
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        step();
        redirect_valid = 1'b0;
        chk("rdw_discard_reqv", {63'd0, imem_req_valid}, 64'd0);
        chk("rdw_addr", imem_req_addr, 64'h8000_1000);
        step();
        chk("rdw_still_discard", {63'd0, imem_req_valid}, 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        chk("rdw_dropped", {63'd0, inst_valid}, 64'd0);
        do_fetch("rdw_new", 64'h8000_1000, 32'h0000_0093, 1);

        // Redirect together with bubble in HOLD: redirect wins
        bubble         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        step();
        bubble         = 1'b0;
        redirect_valid = 1'b0;
        chk("rdh_ivalid", {63'd0, inst_valid}, 64'd0);
        chk("rdh_reqv", {63'd0, imem_req_valid}, 64'd1);
        chk("rdh_addr", imem_req_addr, 64'h8000_2000);

        // Redirect together with a response in WAIT: data dropped
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h8000_3000;
        step();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        chk("rdr_ivalid", {63'd0, inst_valid}, 64'd0);
        chk("rdr_reqv", {63'd0, imem_req_valid}, 64'd1);
        chk("rdr_addr", imem_req_addr, 64'h8000_3000);

        // Redirect together with acceptance in REQ: exactly one response dropped
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_4000;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("rda_reqv", {63'd0, imem_req_valid}, 64'd0);
        chk("rda_addr", imem_req_addr, 64'h8000_4000);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h2222_2222;
        step();
        imem_resp_valid = 1'b0;
        chk("rda_dropped", {63'd0, inst_valid}, 64'd0);
        do_fetch("rda_new", 64'h8000_4000, 32'h0000_0113, 1);

        // Redirect in REQ without acceptance: new address next cycle
        step();
        chk("rdq_seq_addr", imem_req_addr, 64'h8000_4004);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("rdq_reqv", {63'd0, imem_req_valid}, 64'd1);

        // Fetch at the top of the address space, then wrap to zero
        do_fetch("top", 64'hFFFF_FFFF_FFFF_FFFC, 32'h3333_3333, 2);
        step();
        chk("wrap_addr", imem_req_addr, 64'd0);

        // Reset while waiting; late response ignored
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_reqv", {63'd0, imem_req_valid}, 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_addr", imem_req_addr, 64'h8000_0000);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h4444_4444;
        step();
        imem_resp_valid = 1'b0;
        chk("late_ivalid", {63'd0, inst_valid}, 64'd0);
        do_fetch("after_rst", 64'h8000_0000, 32'h0000_0055, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
